// File: rtl/mac_operand_gen.sv
// Operand-pair source feeding the mac a/b valid/ready port (sweeps, ramp, constant).
// Optional build macro MAC_OPERAND_GEN_THROTTLE_EN inserts LFSR-driven idle gaps before each new pair.
module mac_operand_gen #(
    parameter int int_in_lp      = 2,
    parameter int frac_in_lp     = 14,
    parameter int count_width_lp = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                start_i,
    input  logic [1:0]                          mode_i,
    input  logic [count_width_lp-1:0]           count_i,
    input  logic [int_in_lp+frac_in_lp-1:0]     step_i,
    input  logic                                abort_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [int_in_lp+frac_in_lp-1:0]     a_o,
    output logic [int_in_lp+frac_in_lp-1:0]     b_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [count_width_lp-1:0]           issued_o
);
    // state | meaning
    // IDLE  | waiting for start_i
    // LOAD  | one cycle to seed the operands from the latched mode
    // SEND  | presenting pairs to the mac
    // DONE  | one-cycle completion pulse
    localparam int w_lp = int_in_lp + frac_in_lp;
    localparam logic [w_lp-1:0] lsb_lp = {{(w_lp-1){1'b0}}, 1'b1};
    localparam logic [w_lp-1:0] one_lp = lsb_lp << frac_in_lp;
    localparam logic [count_width_lp-1:0] cnt_one_lp = {{(count_width_lp-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                mode_q;
    logic [count_width_lp-1:0] count_q, issued_q;
    logic [w_lp-1:0]           step_q, a_q, b_q;
    logic                      abort_q, valid_q, valid_d, busy_q, done_q;
    logic                      hs, last_pair;

    assign hs = (state_q == S_SEND) & valid_q & ready_i;

    always_comb begin
        last_pair = 1'b0;
        case (mode_q)
            2'd0:    last_pair = (b_q == lsb_lp);
            2'd1:    last_pair = (a_q == lsb_lp);
            default: last_pair = (issued_q == count_q - cnt_one_lp);
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Leaving SEND only ever happens on a handshake, so a pending pair is never dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: begin
                if (abort_i)                                state_d = S_DONE;
                else if (mode_q[1] && (count_q == '0))      state_d = S_DONE;
                else                                        state_d = S_SEND;
            end
            S_SEND: if (hs && (last_pair || abort_q || abort_i)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MAC_OPERAND_GEN_THROTTLE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) lfsr_q <= 16'hACE1;
        else           lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // A presented pair is held until taken; only a fresh pair waits on the LFSR.
    always_comb begin
        valid_d = (state_d == S_SEND) && ((valid_q && !hs) || lfsr_q[0]);
    end
`else
    always_comb begin
        valid_d = (state_d == S_SEND);
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mode_q   <= '0;
            count_q  <= '0;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            issued_q <= '0;
            abort_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= (state_d == S_LOAD) || (state_d == S_SEND);
            done_q  <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q   <= mode_i;
                        count_q  <= count_i;
                        step_q   <= step_i;
                        issued_q <= '0;
                        abort_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    case (mode_q)
                        2'd2:    begin a_q <= '0;     b_q <= one_lp; end
                        2'd3:    begin a_q <= step_q; b_q <= step_q; end
                        default: begin a_q <= one_lp; b_q <= one_lp; end
                    endcase
                end
                S_SEND: begin
                    if (abort_i) abort_q <= 1'b1;
                    if (hs) begin
                        issued_q <= issued_q + cnt_one_lp;
                        case (mode_q)
                            2'd0:    b_q <= b_q >> 1;
                            2'd1:    a_q <= a_q >> 1;
                            2'd2:    a_q <= a_q + step_q;
                            default: ;
                        endcase
                    end
                end
                S_DONE:  abort_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign valid_o  = valid_q;
    assign a_o      = a_q;
    assign b_o      = b_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign issued_o = issued_q;
endmodule

// File: tb/tb_mac_operand_gen.sv
// Scoreboard bench for mac_operand_gen: expected pairs queued at start, popped on each handshake.
module tb_mac_operand_gen;
    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [15:0] count_i = '0;
    logic [15:0] step_i = '0;
    logic        abort_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        valid_o, busy_o, done_o;
    logic [15:0] a_o, b_o, issued_o;

    mac_operand_gen dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .mode_i(mode_i),
        .count_i(count_i), .step_i(step_i), .abort_i(abort_i), .valid_o(valid_o),
        .ready_i(ready_i), .a_o(a_o), .b_o(b_o), .busy_o(busy_o), .done_o(done_o),
        .issued_o(issued_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_edge = 0;
    int last_hs_edge = -1;
    int n_hs = 0;
    bit rnd_ready = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pa = '0, pb = '0;
    logic [31:0] exp_pair;

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_a", a_o, pa);
                chk("hold_b", b_o, pb);
            end
            if (valid_o && ready_i) begin
                n_hs++;
                last_hs_edge = cyc + 1;
                if (sb_q.size() == 0) chk("sb_extra_pair", sb_q.size(), 1);
                else begin
                    exp_pair = sb_q.pop_front();
                    chk("pair_a", a_o, exp_pair[31:16]);
                    chk("pair_b", b_o, exp_pair[15:0]);
                end
            end
            pv = valid_o; pr = ready_i; pa = a_o; pb = b_o;
        end
    end

    always @(posedge clk_i) if (rnd_ready) #1 ready_i = 1'($urandom_range(0, 1));

    task automatic start_seq(input logic [1:0] m, input logic [15:0] c, input logic [15:0] s);
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = m; count_i = c; step_i = s;
        @(posedge clk_i); #1;
        start_edge = cyc;
        start_i = 1'b0;
        mode_i = 2'($urandom); count_i = 16'($urandom); step_i = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        do begin
            @(negedge clk_i);
            i++;
        end while (done_o !== 1'b1 && i < budget);
        if (done_o !== 1'b1) chk({tag, "_timeout"}, done_o, 1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 0);  chk("rst_a", a_o, 0);      chk("rst_b", b_o, 0);
        chk("rst_busy", busy_o, 0);    chk("rst_done", done_o, 0); chk("rst_issued", issued_o, 0);
        reset_ni = 1'b1;

        // B-sweep, ready held high
        ready_i = 1'b1;
        for (int i = 0; i < 15; i++) sb_q.push_back({16'h4000, 16'(16'h4000 >> i)});
        start_seq(2'd0, 16'd0, 16'd0);
        @(negedge clk_i);
        chk("bs_busy_load", busy_o, 1);
        chk("bs_valid_load", valid_o, 0);
        chk("bs_issued_clr", issued_o, 0);
`ifndef MAC_OPERAND_GEN_THROTTLE_EN
        @(negedge clk_i);
        chk("bs_valid_lat", valid_o, 1);
`endif
        wait_done("bs", 300);
        chk("bs_done_lat", cyc, last_hs_edge);
        chk("bs_issued", issued_o, 15);
        chk("bs_sb_empty", sb_q.size(), 0);
        chk("bs_busy_done", busy_o, 0);
        @(negedge clk_i);
        chk("bs_done_pulse", done_o, 0);

        // ramp with wrap, plus an ignored start while busy
        for (int i = 0; i < 20; i++) sb_q.push_back({16'(i * 16'h1000), 16'h4000});
        start_seq(2'd2, 16'd20, 16'h1000);
        repeat (4) @(posedge clk_i);
        #1 start_i = 1'b1; mode_i = 2'd3; count_i = 16'd1; step_i = 16'h7777;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        wait_done("ramp", 300);
        chk("ramp_issued", issued_o, 20);
        chk("ramp_sb_empty", sb_q.size(), 0);

        // A-sweep under random backpressure
        for (int i = 0; i < 15; i++) sb_q.push_back({16'(16'h4000 >> i), 16'h4000});
        n_hs = 0;
        rnd_ready = 1;
        start_seq(2'd1, 16'd0, 16'd0);
        wait_done("asw", 600);
        rnd_ready = 0;
        @(posedge clk_i); #1 ready_i = 1'b1;
        chk("asw_issued", issued_o, 15);
        chk("asw_hs_count", n_hs, 15);
        chk("asw_sb_empty", sb_q.size(), 0);

        // abort after the 3rd handshake with ready low
        for (int i = 0; i < 4; i++) sb_q.push_back({16'h1234, 16'h1234});
        start_seq(2'd3, 16'd10, 16'h1234);
        for (int i = 0; i < 200 && issued_o != 16'd3; i++) begin
            @(posedge clk_i); #1;
        end
        chk("ab_reach3", issued_o, 3);
        ready_i = 1'b0; abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("ab_hold_issued", issued_o, 3);
        chk("ab_no_early_done", done_o, 0);
        ready_i = 1'b1;
        wait_done("ab", 200);
        chk("ab_issued", issued_o, 4);
        chk("ab_sb_empty", sb_q.size(), 0);

        // constant with count 0: no pairs
        start_seq(2'd3, 16'd0, 16'h5555);
        @(negedge clk_i);
        chk("cz_valid0", valid_o, 0);
        chk("cz_done0", done_o, 0);
        @(negedge clk_i);
        chk("cz_valid1", valid_o, 0);
        chk("cz_done1", done_o, 1);
        chk("cz_done_edge", cyc, start_edge + 1);
        chk("cz_issued", issued_o, 0);

        // reset mid-ramp then restart
        for (int i = 0; i < 20; i++) sb_q.push_back({16'(i * 16'h0100), 16'h4000});
        start_seq(2'd2, 16'd20, 16'h0100);
        repeat (6) @(posedge clk_i);
        #3 reset_ni = 1'b0;
        #1;
        chk("mr_valid", valid_o, 0);  chk("mr_a", a_o, 0);      chk("mr_b", b_o, 0);
        chk("mr_busy", busy_o, 0);    chk("mr_done", done_o, 0); chk("mr_issued", issued_o, 0);
        sb_q.delete();
        @(posedge clk_i); #1 reset_ni = 1'b1;
        for (int i = 0; i < 5; i++) sb_q.push_back({16'(i * 16'h0300), 16'h4000});
        start_seq(2'd2, 16'd5, 16'h0300);
        @(negedge clk_i);
        chk("mr_restart_issued", issued_o, 0);
        wait_done("mr", 200);
        chk("mr_issued_end", issued_o, 5);
        chk("mr_sb_empty", sb_q.size(), 0);

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_operand_gen.md
# mac_operand_gen

Synthesizable operand-pair source that drives the `a`/`b` valid/ready input interface of `mac`. On a start command it emits a finite, deterministic sequence of Q(int_in_lp).(frac_in_lp) operand pairs: B-sweep, A-sweep, ramp or constant square. It then reports completion. It replaces testbench-only stimulus for on-chip self-test and sits directly upstream of `mac`, with its `valid_o`/`a_o`/`b_o` wired to the mac's `valid_i`/`a_i`/`b_i`.

## Interface
- `int_in_lp`, 2: integer bits of each operand, including the sign bit.
- `frac_in_lp`, 14: fractional bits of each operand. Operand width W = int_in_lp + frac_in_lp.
- `count_width_lp`, 16: width of the pair count and the issued counter.
- `clk_i`  in  1: clock; all state changes on the rising edge.
- `reset_ni`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: start request, sampled only in IDLE.
- `mode_i`  in  2: sequence select, latched at start. 0 = B-sweep, 1 = A-sweep, 2 = ramp, 3 = constant.
- `count_i`  in  count_width_lp: number of pairs for ramp and constant modes, latched at start. Ignored for sweep modes.
- `step_i`  in  W: ramp increment (mode 2) or constant value (mode 3), latched at start.
- `abort_i`  in  1: terminate the sequence early.
- `valid_o`  out  1: operand pair valid.
- `ready_i`  in  1: downstream accepts the pair.
- `a_o`, `b_o`  out  W each: operands, two's complement fixed point.
- `busy_o`  out  1: high in LOAD and SEND.
- `done_o`  out  1: one-cycle completion pulse.
- `issued_o`  out  count_width_lp: handshakes completed since the last accepted start.

## Operation
- ONE = 1 << frac_in_lp, i.e. 1.0; 0x4000 at default parameters.
- FSM states are IDLE, LOAD, SEND and DONE.
- **IDLE**
  - `valid_o` = 0 and `busy_o` = 0.
  - When `start_i` = 1: latch mode/count/step, clear `issued_o`, and go to LOAD.
- **LOAD** (1 cycle): initialise the operands.
  - B-sweep: a = b = ONE.
  - A-sweep: a = b = ONE.
  - Ramp: a = 0, b = ONE.
  - Constant: a = b = step.
  - If the mode is ramp or constant and count = 0, go to DONE. Otherwise go to SEND.
- **SEND**: `valid_o` = 1. On each cycle with `valid_o` & `ready_i` (a handshake):
  - `issued_o` increments.
  - B-sweep: b <= b >> 1 (logical shift). The last pair is the one sent while b = 1 LSB, giving frac_in_lp+1 pairs (15 at defaults).
  - A-sweep: same as B-sweep, applied to a.
  - Ramp: a <= a + step, modulo 2^W; wrap-around is allowed. The last pair is pair number count.
  - Constant: operands unchanged. The last pair is pair number count.
  - After the last pair, go to DONE.
- **DONE** (1 cycle): `done_o` = 1, then go to IDLE.
- **Handshake rules**
  - Once `valid_o` is asserted, it and `a_o`/`b_o` hold stable until the handshake.
  - `valid_o` never depends combinationally on `ready_i`.
- **Start while busy**: `start_i` outside IDLE is ignored, with no latching and no counter effect.
- **Abort**
  - `abort_i` in LOAD: go to DONE.
  - `abort_i` in SEND with `ready_i` = 1: the current pair completes and counts, then go to DONE.
  - `abort_i` in SEND with `ready_i` = 0: the FSM stays in SEND with `valid_o` held until the pending pair's handshake, then goes to DONE. Abort is sticky until DONE.
  - `abort_i` in IDLE or DONE has no effect.
- **Simultaneous events**: a handshake on the last pair together with `abort_i` goes to DONE once, with a single `done_o` pulse.

## Timing
- **Reset values**: `valid_o` = 0, `a_o` = 0, `b_o` = 0, `busy_o` = 0, `done_o` = 0, `issued_o` = 0, FSM = IDLE.
- **Reset mid-sequence**: all outputs go to these values immediately (asynchronously), with no flush.
- **Start latency**: start sampled at edge k. `busy_o` is high from k. `valid_o` is high from k+1, i.e. after 1 cycle in LOAD, then SEND from k+1 (no-throttle build).
- **Throughput**: with `ready_i` held at 1, one pair per cycle. The next operand is registered at the handshake edge.
- **Completion**: the last handshake occurs at edge m. `done_o` is high during cycle m..m+1, and IDLE is entered at m+1. A new start is accepted at the edge after `done_o` falls.
- **Outputs**: all outputs are registered.

## Configuration
- **Macro**: `MAC_OPERAND_GEN_THROTTLE_EN`.
- **Defined**
  - A 16-bit maximal-length LFSR (seed 0xACE1, advancing every cycle) gates the presentation of each new pair.
  - In SEND, when no pair is pending and LFSR bit 0 = 0, `valid_o` stays 0 for that cycle.
  - Once asserted, `valid_o` is never withdrawn.
  - The LFSR is reset to its seed.
  - Pair values and counts are unchanged.
- **Undefined**
  - No LFSR is present, and `valid_o` is continuously high in SEND.

## Test plan
- B-sweep, `ready_i` held at 1:
  - Expect 15 pairs, a = 0x4000, b = 0x4000, 0x2000, …, 0x0001.
  - `issued_o` = 15, with a `done_o` pulse one cycle after the last handshake.
  - Chained into `mac`, the final data_o equals the sum of products.
- Ramp, step = 0x1000, count = 20:
  - a follows 0x0000, 0x1000, …, wrapping after 0xF000 to 0x0000.
  - b = 0x4000 for all pairs, and `issued_o` = 20.
- Random `ready_i` backpressure during an A-sweep: `valid_o`/`a_o`/`b_o` stay stable while `ready_i` = 0, with no dropped or duplicated pairs (15 total).
- Abort:
  - Abort after the 3rd handshake of a constant mode with count = 10 and `ready_i` = 0: the pending 4th pair holds until ready, then `done_o` pulses with `issued_o` = 4.
  - Constant mode with count = 0: `done_o` pulses 2 cycles after start and `valid_o` never rises.
- Deassert `reset_ni` mid-ramp: all outputs go to 0 immediately, and a `start_i` pulse after release restarts with `issued_o` = 0.
- THROTTLE_EN build, B-sweep with `ready_i` = 1: the same 15 pairs appear, with idle gaps and `valid_o` never falling before a handshake.
